// File: rtl/wfg_stim_sine_gen.sv
// Iterative-CORDIC sine stimulus generator with AXI-stream style output.
// One micro-rotation per clock; the sample is scaled by gain, offset and
// saturated, then held until the downstream handshake advances the phase.
// Optional cosine channel: define WFG_STIM_SINE_GEN_QUAD_EN.

module wfg_stim_sine_gen #(
    parameter int PHASE_W = 16,
    parameter int OUT_W   = 18,
    parameter int ITER    = 16,
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
    localparam int NCH    = 2
`else
    localparam int NCH    = 1
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctrl_en_q_i,
    input  logic                   ctrl_phase_clr_q_i,
    input  logic [PHASE_W-1:0]     inc_val_q_i,
    input  logic [15:0]            gain_val_q_i,
    input  logic [OUT_W-1:0]       offset_val_q_i,
    input  logic                   wfg_axis_tready_i,
    output logic                   wfg_axis_tvalid_o,
    output logic [NCH*OUT_W-1:0]   wfg_axis_tdata_o
);

    // CORDIC datapath width, iteration counter width, product width
    localparam int DW = PHASE_W + 2;
    localparam int IW = $clog2(ITER);
    localparam int PW = DW + 17;
    // Product shift that maps 1.0 * gain(1.0) onto the OUT_W full scale
    localparam int SH = PHASE_W + 15 - (OUT_W - 1);

    localparam logic signed [DW-1:0] K_INIT =
        DW'($rtoi(0.607253 * (2.0 ** PHASE_W) + 0.5));

    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, SCALE, DONE} state_t;

    state_t                    state, state_n;
    logic [PHASE_W-1:0]        phase_acc, phase_n;
    logic signed [DW-1:0]      x, x_n;
    logic signed [DW-1:0]      y, y_n;
    logic signed [DW-1:0]      z, z_n;
    logic [IW-1:0]             iter, iter_n;
    logic [1:0]                quad, quad_n;
    logic                      tvalid, tvalid_n;
    logic [NCH*OUT_W-1:0]      tdata, tdata_n;

    logic signed [DW-1:0]      atan_tab [ITER];
    logic signed [16:0]        gain_c;
    logic signed [DW-1:0]      sin_ch;
    logic [OUT_W-1:0]          sin_r;
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
    logic signed [DW-1:0]      cos_ch;
    logic [OUT_W-1:0]          cos_r;
`endif

    // Arctangent table in phase units (2^PHASE_W = full turn), built at elaboration
    for (genvar g = 0; g < ITER; g++) begin : g_atan
        localparam int A = (g == 0) ? (1 << (PHASE_W - 3)) :
            $rtoi($atan(1.0 / (2.0 ** g)) * (2.0 ** (PHASE_W - 1)) / 3.14159265358979 + 0.5);
        assign atan_tab[g] = DW'(A);
    end

    // Gain above unity is clamped to 0x7FFF; kept positive in a signed operand
    assign gain_c = gain_val_q_i[15] ? 17'sh07FFF : $signed({1'b0, gain_val_q_i});

    // Scale one channel by gain, add offset and saturate to the OUT_W range;
    // the sum is formed at full product width so it can never wrap.
    function automatic logic [OUT_W-1:0] scale_sat(
        input logic signed [DW-1:0]    ch,
        input logic signed [16:0]      g,
        input logic signed [OUT_W-1:0] off
    );
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] r;
        p = PW'(ch) * PW'(g);
        r = (p >>> SH) + PW'(off);
        if (r > SAT_MAX) begin
            return OUT_MAX;
        end else if (r < SAT_MIN) begin
            return OUT_MIN;
        end
        return r[OUT_W-1:0];
    endfunction

    // Fold the first-quadrant CORDIC result back into the sampled quadrant
    always_comb begin
        sin_ch = y;
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
        cos_ch = x;
`endif
        case (quad)
            2'd1: begin
                sin_ch = x;
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
                cos_ch = -y;
`endif
            end
            2'd2: begin
                sin_ch = -y;
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
                cos_ch = -x;
`endif
            end
            2'd3: begin
                sin_ch = -x;
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
                cos_ch = y;
`endif
            end
            default: begin
                sin_ch = y;
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
                cos_ch = x;
`endif
            end
        endcase
    end

    assign sin_r = scale_sat(sin_ch, gain_c, offset_val_q_i);
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
    assign cos_r = scale_sat(cos_ch, gain_c, offset_val_q_i);
`endif

    // Next-state and next-datapath values for the sample sequencer
    always_comb begin
        state_n  = state;
        phase_n  = phase_acc;
        x_n      = x;
        y_n      = y;
        z_n      = z;
        iter_n   = iter;
        quad_n   = quad;
        tvalid_n = tvalid;
        tdata_n  = tdata;
        case (state)
            IDLE: begin
                if (ctrl_phase_clr_q_i) begin
                    phase_n = '0;
                end else if (ctrl_en_q_i) begin
                    quad_n  = phase_acc[PHASE_W-1 -: 2];
                    z_n     = DW'(phase_acc[PHASE_W-3:0]);
                    x_n     = K_INIT;
                    y_n     = '0;
                    iter_n  = '0;
                    state_n = CALC;
                end
            end
            CALC: begin
                if (z[DW-1]) begin
                    x_n = x + (y >>> iter);
                    y_n = y - (x >>> iter);
                    z_n = z + atan_tab[iter];
                end else begin
                    x_n = x - (y >>> iter);
                    y_n = y + (x >>> iter);
                    z_n = z - atan_tab[iter];
                end
                iter_n = iter + IW'(1);
                if (iter == IW'(ITER - 1)) begin
                    state_n = SCALE;
                end
            end
            SCALE: begin
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
                tdata_n = {cos_r, sin_r};
`else
                tdata_n = sin_r;
`endif
                tvalid_n = 1'b1;
                state_n  = DONE;
            end
            DONE: begin
                if (wfg_axis_tready_i) begin
                    tvalid_n = 1'b0;
                    phase_n  = phase_acc + inc_val_q_i;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_acc <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            iter      <= '0;
            quad      <= '0;
            tvalid    <= 1'b0;
            tdata     <= '0;
        end else begin
            phase_acc <= phase_n;
            x         <= x_n;
            y         <= y_n;
            z         <= z_n;
            iter      <= iter_n;
            quad      <= quad_n;
            tvalid    <= tvalid_n;
            tdata     <= tdata_n;
        end
    end

    assign wfg_axis_tvalid_o = tvalid;
    assign wfg_axis_tdata_o  = tdata;

endmodule

// File: tb/tb_wfg_stim_sine_gen.sv
// Bench for wfg_stim_sine_gen: an ideal sin/cos model (real arithmetic)
// is compared against every valid sample; directed tests pin saturation,
// gain clamping, back-pressure, latency and reset behaviour.

module tb_wfg_stim_sine_gen;

    localparam int PHASE_W = 16;
    localparam int OUT_W   = 18;
    localparam int ITER    = 16;
    localparam int ITER_B  = 10;
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
    localparam int NCH = 2;
`else
    localparam int NCH = 1;
`endif
    localparam int SH   = PHASE_W + 15 - (OUT_W - 1);
    localparam int SMAX = (1 << (OUT_W - 1)) - 1;
    localparam int SMIN = -(1 << (OUT_W - 1));
    // Allowance for CORDIC angle-table rounding and shift truncation
    localparam int TOL  = 48;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0, en_b = 1'b0, clr = 1'b0, tready = 1'b1;
    logic [PHASE_W-1:0]   inc = '0;
    logic [15:0]          gain = '0;
    logic [OUT_W-1:0]     offset = '0;
    logic                 tvalid, tvalid_b;
    logic [NCH*OUT_W-1:0] tdata, tdata_b;

    int checks = 0;
    int passes = 0;
    int unsigned mph = 0;

    always #5 clk = ~clk;

    wfg_stim_sine_gen #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .ITER(ITER)) dut (
        .clk(clk), .rst(rst), .ctrl_en_q_i(en), .ctrl_phase_clr_q_i(clr),
        .inc_val_q_i(inc), .gain_val_q_i(gain), .offset_val_q_i(offset),
        .wfg_axis_tready_i(tready), .wfg_axis_tvalid_o(tvalid), .wfg_axis_tdata_o(tdata)
    );

    wfg_stim_sine_gen #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .ITER(ITER_B)) dut_b (
        .clk(clk), .rst(rst), .ctrl_en_q_i(en_b), .ctrl_phase_clr_q_i(clr),
        .inc_val_q_i(inc), .gain_val_q_i(gain), .offset_val_q_i(offset),
        .wfg_axis_tready_i(tready), .wfg_axis_tvalid_o(tvalid_b), .wfg_axis_tdata_o(tdata_b)
    );

    function automatic int sext(input logic [OUT_W-1:0] v);
        logic signed [OUT_W-1:0] t;
        t = v;
        return int'(t);
    endfunction

    // Ideal channel value: trig of the phase angle, full-scale 1.0*gain, offset, clip
    function automatic int model_chan(input int unsigned ph, input bit cosine,
                                      input int unsigned g_raw, input int off);
        real ang, v, s;
        int unsigned g;
        int r;
        ang = 2.0 * 3.14159265358979 * real'(ph) / (2.0 ** PHASE_W);
        v   = cosine ? $cos(ang) : $sin(ang);
        g   = (g_raw > 32767) ? 32767 : g_raw;
        s   = v * (2.0 ** PHASE_W) * real'(g) / (2.0 ** SH);
        r   = int'(s) + off;
        if (r > SMAX) r = SMAX;
        if (r < SMIN) r = SMIN;
        return r;
    endfunction

    task automatic check_int(input string name, input int act, input int exp, input int tol);
        int d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d <= tol) passes++;
        else $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
    endtask

    // Phase seen by the model: advances by inc on each handshake
    always @(posedge clk) begin
        if (rst) mph = 0;
        else if (tvalid && tready) mph = (mph + int'(inc)) & 32'hFFFF;
        else if (clr) mph = 0;
    end

    // Compare every valid sample against the ideal model
    always @(negedge clk) begin
        if (!rst && tvalid) begin
            check_int("model_sine", sext(tdata[OUT_W-1:0]),
                      model_chan(mph, 1'b0, int'(gain), sext(offset)), TOL);
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
            check_int("model_cosine", sext(tdata[2*OUT_W-1:OUT_W]),
                      model_chan(mph, 1'b1, int'(gain), sext(offset)), TOL);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(output logic [NCH*OUT_W-1:0] d);
        d = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tvalid) begin
                d = tdata;
                return;
            end
        end
        checks++;
        $display("FAIL wait_valid: got no tvalid, want tvalid within 200 cycles");
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    // Produce one sample at phase ph (phase 0 first when ph != 0)
    task automatic get_at(input logic [PHASE_W-1:0] ph, output logic [NCH*OUT_W-1:0] d);
        en = 1'b0;
        tick(3);
        clr_pulse();
        inc = ph;
        en = 1'b1;
        wait_valid(d);
        if (ph != '0) wait_valid(d);
        en = 1'b0;
        tick(2);
    endtask

    // Edges from the en-sampling edge (edge 1) to tvalid, then rise-to-rise period
    task automatic lat(input bit b, output int first, output int period);
        first = 0;
        period = 0;
        @(negedge clk);
        if (b) en_b = 1'b1; else en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (b ? tvalid_b : tvalid) begin first = i; break; end
        end
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (b ? tvalid_b : tvalid) begin period = i; break; end
        end
        en = 1'b0;
        en_b = 1'b0;
        tick(30);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        logic [NCH*OUT_W-1:0] d, d0;
        int lit_s [4] = '{0, 131068, 0, -131068};
        int lit_c [4] = '{131068, 0, -131068, 0};
        int first, period, seen;

        tick(3);
        check_int("reset_tvalid", int'(tvalid), 0, 0);
        check_int("reset_tdata_zero", (tdata == '0) ? 1 : 0, 1, 0);
        rst = 1'b0;
        gain = 16'h7FFF;
        offset = '0;
        tready = 1'b1;
        tick(2);

        // Four quadrant points
        clr_pulse();
        inc = 16'h4000;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(d);
            if (k == 3) en = 1'b0;
            check_int("quad_sine", sext(d[OUT_W-1:0]), lit_s[k], TOL);
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
            check_int("quad_cosine", sext(d[2*OUT_W-1:OUT_W]), lit_c[k], TOL);
`endif
        end
        tick(3);

        // Saturation at both rails
        offset = 18'h10000;
        get_at(16'h4000, d);
        check_int("sat_high", int'(d[OUT_W-1:0]), 'h1FFFF, 0);
        offset = 18'h30000;
        get_at(16'hC000, d);
        check_int("sat_low", int'(d[OUT_W-1:0]), 'h20000, 0);
        offset = '0;

        // Gain clamp: 0xFFFF behaves as 0x7FFF
        gain = 16'h7FFF;
        get_at(16'h2000, d);
        check_int("gain7fff_sine", sext(d[OUT_W-1:0]), 92680, TOL);
        gain = 16'hFFFF;
        get_at(16'h2000, d);
        check_int("gainffff_sine", sext(d[OUT_W-1:0]), 92680, TOL);
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
        check_int("gainffff_cosine", sext(d[2*OUT_W-1:OUT_W]), 92680, TOL);
`endif
        gain = 16'h7FFF;

        // Back-pressure: sample held, then phase advances by one inc
        tick(2);
        clr_pulse();
        inc = 16'h1000;
        tready = 1'b0;
        en = 1'b1;
        wait_valid(d0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_int("stall_tvalid", int'(tvalid), 1, 0);
            check_int("stall_sine_stable", sext(tdata[OUT_W-1:0]), sext(d0[OUT_W-1:0]), 0);
        end
        tready = 1'b1;
        wait_valid(d);
        en = 1'b0;
        check_int("adv_sine", sext(d[OUT_W-1:0]), 50158, TOL);
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
        check_int("adv_cosine", sext(d[2*OUT_W-1:OUT_W]), 121091, TOL);
`endif
        tick(3);

        // Latency and throughput for both iteration counts
        lat(1'b0, first, period);
        check_int("latency_iter16", first, ITER + 2, 0);
        check_int("period_iter16", period, ITER + 3, 0);
        lat(1'b1, first, period);
        check_int("latency_iter10", first, ITER_B + 2, 0);
        check_int("period_iter10", period, ITER_B + 3, 0);

        // Asynchronous reset while a sample is held
        clr_pulse();
        inc = '0;
        tready = 1'b0;
        en = 1'b1;
        wait_valid(d);
        en = 1'b0;
        tick(2);
        #2 rst = 1'b1;
        #1;
        check_int("async_rst_tvalid", int'(tvalid), 0, 0);
        check_int("async_rst_tdata_zero", (tdata == '0) ? 1 : 0, 1, 0);
        tick(2);
        rst = 1'b0;
        tready = 1'b1;
        tick(2);

        // Reset during CALC emits no partial sample
        en = 1'b1;
        tick(6);
        #2 rst = 1'b1;
        en = 1'b0;
        tick(2);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (tvalid) seen++;
        end
        check_int("no_partial_sample", seen, 0, 0);

        clr_pulse();
        en = 1'b1;
        wait_valid(d);
        en = 1'b0;
        check_int("post_rst_sine", sext(d[OUT_W-1:0]), 0, TOL);
`ifdef WFG_STIM_SINE_GEN_QUAD_EN
        check_int("post_rst_cosine", sext(d[2*OUT_W-1:OUT_W]), 131068, TOL);
`endif
        tick(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
